// File: rtl/avmm_pkg.sv
// rtl/avmm_pkg.sv - shared widths and enums for the two-requester Avalon-MM arbiter
package avmm_pkg;

  localparam int AVM_ADDR_W = 32;
  localparam int AVM_DATA_W = 16;
  localparam int AVM_BE_W   = 2;

  typedef enum logic {REQ_SDR, REQ_TRI} req_id_t;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/rd_owner_fifo.sv
// rtl/rd_owner_fifo.sv - in-order FIFO of 1-bit read owners, one entry per outstanding read
module rd_owner_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ptr_one;

  assign ptr_one = {{AW{1'b0}}, 1'b1};

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + ptr_one;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_id;
    end
  end

endmodule

// File: rtl/avmm_arbiter2.sv
// rtl/avmm_arbiter2.sv - round-robin arbiter sharing one Avalon-MM SDRAM port between two masters
module avmm_arbiter2
  import avmm_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [AVM_ADDR_W-1:0] m0_address,
  input  logic [AVM_BE_W-1:0]   m0_byteenable,
  input  logic [AVM_DATA_W-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [AVM_DATA_W-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [AVM_ADDR_W-1:0] m1_address,
  input  logic [AVM_BE_W-1:0]   m1_byteenable,
  input  logic [AVM_DATA_W-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [AVM_DATA_W-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic [AVM_BE_W-1:0]   avm_byteenable,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  err
);

  arb_state_t state_q, state_d;
  req_id_t    owner_q, owner_d;
  req_id_t    rr_next_q, rr_next_d;
  logic       err_q, err_d;

  logic req0, req1;
  logic own_rd, own_wr;
  logic granted, read_block, cmd_rd, cmd_wr, accept;
  logic fifo_full, fifo_empty, fifo_head, rsp_pop;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign own_rd  = (owner_q == REQ_TRI) ? m1_read  : m0_read;
  assign own_wr  = (owner_q == REQ_TRI) ? m1_write : m0_write;
  assign granted = rstn && (state_q == ARB_GRANT);

  // Read+write together is an error and is treated as a read.
  assign read_block = granted && own_rd && fifo_full;
  assign cmd_rd     = granted && own_rd && !fifo_full;
  assign cmd_wr     = granted && own_wr && !own_rd;
  assign accept     = (cmd_rd || cmd_wr) && !avm_waitrequest;
  assign rsp_pop    = rstn && avm_readdatavalid && !fifo_empty;

  rd_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rd_owner_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (accept && cmd_rd),
    .push_id (owner_q),
    .pop     (rsp_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign avm_read       = cmd_rd;
  assign avm_write      = cmd_wr;
  assign avm_address    = !granted ? '0 : (owner_q == REQ_TRI) ? m1_address    : m0_address;
  assign avm_byteenable = !granted ? '0 : (owner_q == REQ_TRI) ? m1_byteenable : m0_byteenable;
  assign avm_writedata  = !granted ? '0 : (owner_q == REQ_TRI) ? m1_writedata  : m0_writedata;

  assign m0_waitrequest = (granted && owner_q == REQ_SDR) ? (avm_waitrequest || read_block) : 1'b1;
  assign m1_waitrequest = (granted && owner_q == REQ_TRI) ? (avm_waitrequest || read_block) : 1'b1;

  // Data fans out to both; only the valid pulse is steered by the FIFO head.
  assign m0_readdata      = avm_readdata;
  assign m1_readdata      = avm_readdata;
  assign m0_readdatavalid = rsp_pop && (fifo_head == 1'b0);
  assign m1_readdatavalid = rsp_pop && (fifo_head == 1'b1);
  assign err              = err_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_next_d = rr_next_q;
    err_d     = err_q;
    if (state_q == ARB_IDLE) begin
      if (req0 || req1) begin
        state_d = ARB_GRANT;
        if (req0 && req1) begin
          owner_d = rr_next_q;
        end else begin
          owner_d = req1 ? REQ_TRI : REQ_SDR;
        end
      end
    end else begin
      if (accept) begin
        rr_next_d = (owner_q == REQ_SDR) ? REQ_TRI : REQ_SDR;
        state_d   = ARB_IDLE;
      end else if (!(own_rd || own_wr)) begin
        state_d = ARB_IDLE;
      end
    end
    if ((m0_read && m0_write) || (m1_read && m1_write) || (avm_readdatavalid && fifo_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      owner_q   <= REQ_SDR;
      rr_next_q <= REQ_SDR;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_next_q <= rr_next_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_avmm_arbiter2.sv
// tb/tb_avmm_arbiter2.sv - randomized and directed bench for avmm_arbiter2 against a queue-based model
module tb_avmm_arbiter2;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
  logic [31:0] m0_address;
  logic [1:0]  m0_byteenable;
  logic [15:0] m0_writedata, m0_readdata;
  logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m1_address;
  logic [1:0]  m1_byteenable;
  logic [15:0] m1_writedata, m1_readdata;
  logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid, err;
  logic [31:0] avm_address;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_writedata, avm_readdata;

  avmm_arbiter2 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .err(err)
  );

  // Requester command slots
  bit          cmd_v  [2];
  bit          cmd_rd [2];
  logic [31:0] cmd_addr [2];
  logic [1:0]  cmd_be [2];
  logic [15:0] cmd_wd [2];
  int          rep [2];

  int          req_pct, wait_pct, ret_pct;
  bit          seq_data;
  logic [15:0] seq_val;

  // Model: grant status, owner, favoured requester, outstanding-read owners in order
  bit          m_busy, m_err;
  int          m_own, m_rr;
  int          sq [$];

  logic        e_wr0, e_wr1, e_ar, e_aw, e_rdv0, e_rdv1;
  logic [31:0] e_addr;
  logic [1:0]  e_be;
  logic [15:0] e_wd;
  bit          e_acc, o_rd, o_wr;

  logic [31:0] acc_log [$];
  int          ret_req [$];
  logic [15:0] ret_dat [$];

  int vec = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    m0_read       = cmd_v[0] && cmd_rd[0];
    m0_write      = cmd_v[0] && !cmd_rd[0];
    m0_address    = cmd_addr[0];
    m0_byteenable = cmd_be[0];
    m0_writedata  = cmd_wd[0];
    m1_read       = cmd_v[1] && cmd_rd[1];
    m1_write      = cmd_v[1] && !cmd_rd[1];
    m1_address    = cmd_addr[1];
    m1_byteenable = cmd_be[1];
    m1_writedata  = cmd_wd[1];
  endtask

  task automatic eval();
    bit full;
    full = (sq.size() >= MAXO);
    e_wr0 = 1; e_wr1 = 1; e_ar = 0; e_aw = 0; e_rdv0 = 0; e_rdv1 = 0;
    e_addr = 0; e_be = 0; e_wd = 0; e_acc = 0; o_rd = 0; o_wr = 0;
    if (rstn && m_busy) begin
      if (m_own == 0) begin
        o_rd = m0_read; o_wr = m0_write; e_addr = m0_address; e_be = m0_byteenable; e_wd = m0_writedata;
      end else begin
        o_rd = m1_read; o_wr = m1_write; e_addr = m1_address; e_be = m1_byteenable; e_wd = m1_writedata;
      end
      e_ar = o_rd && !full;
      e_aw = o_wr && !o_rd;
      if (m_own == 0) e_wr0 = avm_waitrequest || (o_rd && full);
      else            e_wr1 = avm_waitrequest || (o_rd && full);
      e_acc = (e_ar || e_aw) && !avm_waitrequest;
    end
    if (rstn && avm_readdatavalid && sq.size() > 0) begin
      if (sq[0] == 0) e_rdv0 = 1;
      else            e_rdv1 = 1;
    end
  endtask

  task automatic compare();
    eval();
    check("m0_waitrequest", m0_waitrequest, e_wr0);
    check("m1_waitrequest", m1_waitrequest, e_wr1);
    check("avm_read", avm_read, e_ar);
    check("avm_write", avm_write, e_aw);
    check("m0_readdatavalid", m0_readdatavalid, e_rdv0);
    check("m1_readdatavalid", m1_readdatavalid, e_rdv1);
    check("err", err, m_err);
    if (e_ar || e_aw) begin
      check("avm_address", avm_address, e_addr);
      check("avm_byteenable", avm_byteenable, e_be);
      if (e_aw) check("avm_writedata", avm_writedata, e_wd);
    end
    if (e_rdv0) check("m0_readdata", m0_readdata, avm_readdata);
    if (e_rdv1) check("m1_readdata", m1_readdata, avm_readdata);
    if ((avm_read || avm_write) && !avm_waitrequest) acc_log.push_back(avm_address);
    if (m0_readdatavalid) begin ret_req.push_back(0); ret_dat.push_back(m0_readdata); end
    if (m1_readdatavalid) begin ret_req.push_back(1); ret_dat.push_back(m1_readdata); end
  endtask

  task automatic update();
    bit r0, r1;
    r0 = m0_read || m0_write;
    r1 = m1_read || m1_write;
    if (!rstn) begin
      m_busy = 0; m_own = 0; m_rr = 0; m_err = 0;
      sq.delete();
      cmd_v[0] = 0; cmd_v[1] = 0; rep[0] = 0; rep[1] = 0;
    end else begin
      if (avm_readdatavalid) begin
        if (sq.size() == 0) m_err = 1;
        else void'(sq.pop_front());
      end
      if ((m0_read && m0_write) || (m1_read && m1_write)) m_err = 1;
      if (!m_busy) begin
        if (r0 || r1) begin
          m_busy = 1;
          m_own  = (r0 && r1) ? m_rr : (r1 ? 1 : 0);
        end
      end else if (e_acc) begin
        if (e_ar) sq.push_back(m_own);
        cmd_v[m_own] = 0;
        m_rr   = 1 - m_own;
        m_busy = 0;
      end else if (!(o_rd || o_wr)) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (!cmd_v[k]) begin
        if (rep[k] > 0) begin
          rep[k]--;
          cmd_v[k] = 1;
        end else if ($urandom_range(99) < req_pct) begin
          cmd_v[k]    = 1;
          cmd_rd[k]   = $urandom_range(1);
          cmd_addr[k] = $urandom & 32'hFFFF_FFFE;
          cmd_be[k]   = 2'($urandom_range(3));
          cmd_wd[k]   = 16'($urandom);
        end
      end
    end
    apply();
    avm_waitrequest   = ($urandom_range(99) < wait_pct);
    avm_readdatavalid = (sq.size() > 0) && ($urandom_range(99) < ret_pct);
    if (seq_data) begin
      avm_readdata = seq_val;
      if (avm_readdatavalid) seq_val = seq_val + 16'h1111;
    end else begin
      avm_readdata = 16'($urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
    drive();
  endtask

  task automatic do_reset(input int n);
    rstn = 0;
    cmd_v[0] = 0; cmd_v[1] = 0;
    apply();
    repeat (n) cycle();
    rstn = 1;
  endtask

  task automatic issue(input int k, input bit rd, input logic [31:0] addr, input logic [15:0] wd);
    int n;
    cmd_v[k] = 1; cmd_rd[k] = rd; cmd_addr[k] = addr; cmd_be[k] = 2'b11; cmd_wd[k] = wd;
    apply();
    n = 0;
    while (cmd_v[k] && n < 60) begin cycle(); n++; end
    check("issue_done", cmd_v[k], 0);
  endtask

  task automatic drain();
    int n;
    req_pct = 0; ret_pct = 100; wait_pct = 0;
    n = 0;
    while ((sq.size() > 0 || cmd_v[0] || cmd_v[1]) && n < 200) begin cycle(); n++; end
    check("drain_done", sq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rstn = 0;
    req_pct = 0; wait_pct = 0; ret_pct = 0; seq_data = 0; seq_val = 16'h1111;
    m_busy = 0; m_own = 0; m_rr = 0; m_err = 0;
    for (int k = 0; k < 2; k++) begin
      cmd_v[k] = 0; cmd_rd[k] = 0; cmd_addr[k] = 0; cmd_be[k] = 0; cmd_wd[k] = 0; rep[k] = 0;
    end
    apply();
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
    do_reset(2);

    // Reset state
    #1;
    check("rst_err", err, 0);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_write", avm_write, 0);

    // Single read by m0, data 0xBEEF returned 3 cycles after accept
    cmd_v[0] = 1; cmd_rd[0] = 1; cmd_addr[0] = 32'h0; cmd_be[0] = 2'b11;
    apply();
    #1;
    check("t1_idle_no_read", avm_read, 0);
    cycle(); #1;
    check("t1_avm_read", avm_read, 1);
    check("t1_addr", avm_address, 32'h0);
    check("t1_m0_wait", m0_waitrequest, 0);
    check("t1_m1_wait", m1_waitrequest, 1);
    cycle(); cycle(); cycle();
    avm_readdatavalid = 1; avm_readdata = 16'hBEEF;
    #1;
    check("t1_m0_rdv", m0_readdatavalid, 1);
    check("t1_m0_data", m0_readdata, 16'hBEEF);
    check("t1_m1_rdv", m1_readdatavalid, 0);
    cycle();
    check("t1_err", err, 0);

    // Both request continuously: grants alternate and returns are steered in order
    do_reset(1);
    acc_log.delete(); ret_req.delete(); ret_dat.delete();
    seq_data = 1; seq_val = 16'h1111; ret_pct = 50;
    cmd_v[0] = 1; cmd_rd[0] = 1; cmd_addr[0] = 32'h1C; cmd_be[0] = 2'b11;
    cmd_v[1] = 1; cmd_rd[1] = 1; cmd_addr[1] = 32'h40; cmd_be[1] = 2'b11;
    rep[0] = 3; rep[1] = 3;
    apply();
    n = 0;
    while ((cmd_v[0] || cmd_v[1] || rep[0] > 0 || rep[1] > 0 || sq.size() > 0) && n < 300) begin
      cycle(); n++;
    end
    check("t2_accepts", acc_log.size(), 8);
    check("t2_returns", ret_req.size(), 8);
    for (int i = 0; i < 8 && i < acc_log.size() && i < ret_req.size(); i++) begin
      check("t2_addr_order", acc_log[i], (i % 2) ? 32'h40 : 32'h1C);
      check("t2_ret_owner", ret_req[i], i % 2);
      check("t2_ret_data", {16'h0, ret_dat[i]}, 32'h1111 * (i + 1));
    end
    seq_data = 0;

    // Stall of 5 cycles on an m1 read while m0 also waits
    do_reset(1);
    acc_log.delete();
    ret_pct = 0; wait_pct = 100;
    cmd_v[1] = 1; cmd_rd[1] = 1; cmd_addr[1] = 32'h40; cmd_be[1] = 2'b11;
    apply();
    cycle();
    cmd_v[0] = 1; cmd_rd[0] = 1; cmd_addr[0] = 32'h1C; cmd_be[0] = 2'b11;
    apply();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_avm_read", avm_read, 1);
      check("t3_addr", avm_address, 32'h40);
      check("t3_m0_wait", m0_waitrequest, 1);
      check("t3_m1_wait", m1_waitrequest, 1);
      cycle();
    end
    wait_pct = 0; avm_waitrequest = 0;
    n = 0;
    while ((cmd_v[0] || cmd_v[1]) && n < 20) begin cycle(); n++; end
    check("t3_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      check("t3_first", acc_log[0], 32'h40);
      check("t3_second", acc_log[1], 32'h1C);
    end
    drain();

    // Owner FIFO full: 9th read stalls until one word returns
    do_reset(1);
    ret_pct = 0; wait_pct = 0;
    for (int i = 0; i < MAXO; i++) issue(0, 1, 32'(i * 2), 16'h0);
    cmd_v[0] = 1; cmd_rd[0] = 1; cmd_addr[0] = 32'h100; cmd_be[0] = 2'b11;
    apply();
    cycle(); #1;
    check("t4_blocked_wait", m0_waitrequest, 1);
    check("t4_blocked_read", avm_read, 0);
    cycle();
    avm_readdatavalid = 1;
    #1;
    check("t4_full_with_pop_read", avm_read, 0);
    check("t4_pop_rdv", m0_readdatavalid, 1);
    cycle(); #1;
    check("t4_unblocked_read", avm_read, 1);
    check("t4_unblocked_addr", avm_address, 32'h100);
    check("t4_unblocked_wait", m0_waitrequest, 0);
    n = 0;
    while (cmd_v[0] && n < 20) begin cycle(); n++; end
    drain();

    // Write from m0 interleaved with m1 reads outstanding
    do_reset(1);
    ret_pct = 0;
    issue(1, 1, 32'h40, 16'h0);
    issue(1, 1, 32'h42, 16'h0);
    ret_req.delete();
    issue(0, 0, 32'h18, 16'hBEEF);
    drain();
    check("t5_returns", ret_req.size(), 2);
    if (ret_req.size() == 2) begin
      check("t5_owner0", ret_req[0], 1);
      check("t5_owner1", ret_req[1], 1);
    end

    // Unexpected return, sticky err, and reset clearing it
    do_reset(1);
    avm_readdatavalid = 1; avm_readdata = 16'h1234;
    #1;
    check("t6_no_rdv0", m0_readdatavalid, 0);
    check("t6_no_rdv1", m1_readdatavalid, 0);
    cycle(); #1;
    check("t6_err_set", err, 1);
    cycle(); #1;
    check("t6_err_sticky", err, 1);
    rstn = 0;
    cycle();
    rstn = 1;
    #1;
    check("t6_err_cleared", err, 0);
    check("t6_m0_wait", m0_waitrequest, 1);
    check("t6_avm_read", avm_read, 0);
    m0_read = 1; m0_write = 1;
    cycle(); #1;
    check("t6_rw_err", err, 1);
    cycle();

    // Randomized traffic
    do_reset(1);
    req_pct = 35; wait_pct = 30; ret_pct = 40;
    repeat (3000) cycle();
    drain();
    do_reset(1);
    req_pct = 80; wait_pct = 10; ret_pct = 15;
    repeat (1500) cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
